// File: rtl/cmul_seq.sv
`timescale 1ns/1ps
// cmul_seq: complex twiddle-multiply sequencer for the 64-point FFT datapath.
// One complex Q1.15 sample and twiddle are accepted. The four partial products
// are formed on one shared external 16x16 signed multiplier over four cycles
// and accumulated. The sums are rounded back to Q1.15 and presented on a
// valid/ready output.
//
// Parameters:
//   FRAC_BITS  fractional bits of the I/O format (product shift)
//   CONJ       1 = multiply by the conjugate twiddle (IFFT), 0 = plain
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   in_valid / in_ready               input handshake
//   a_re, a_im, w_re, w_im            sample and twiddle, signed Q1.15
//   mul_multiplier, mul_multiplicand  operands to the shared multiplier
//   mul_result                        combinational signed product from it
//   out_valid / out_ready             output handshake
//   y_re, y_im                        rounded result, signed Q1.15
//   sat_flag                          result was clamped (saturating build)
//
// Build option: define CMUL_SAT_EN to saturate out-of-range results.
// Without it, results wrap to 16 bits and sat_flag stays 0.
module cmul_seq #(
    parameter int unsigned FRAC_BITS = 15,
    parameter bit          CONJ      = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_re,
    input  logic [15:0] a_im,
    input  logic [15:0] w_re,
    input  logic [15:0] w_im,
    output logic [15:0] mul_multiplier,
    output logic [15:0] mul_multiplicand,
    input  logic [31:0] mul_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y_re,
    output logic [15:0] y_im,
    output logic        sat_flag
);

    localparam int unsigned ACC_W = 33;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P0   = 3'd1;
    localparam logic [2:0] S_P1   = 3'd2;
    localparam logic [2:0] S_P2   = 3'd3;
    localparam logic [2:0] S_P3   = 3'd4;
    localparam logic [2:0] S_RND  = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);
`ifdef CMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-16){1'b0}}, 16'h7FFF};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-16){1'b1}}, 16'h8000};
`endif

    logic [2:0]              state_q, state_d;
    logic                    rdy_en_q;
    logic [15:0]             ar_q, ai_q, wr_q, wi_q;
    logic [15:0]             ar_d, ai_d, wr_d, wi_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [15:0]             y_re_q, y_re_d, y_im_q, y_im_d;
    logic                    sat_q, sat_d;
    logic                    accept;
    logic signed [ACC_W-1:0] prod_ext;
    logic [16:0]             rnd_re, rnd_im;

    // Returns {clamped, value}: round-half-up, then saturate or wrap.
    function automatic logic [16:0] round_q(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] t;
        t = (acc + HALF) >>> FRAC_BITS;
`ifdef CMUL_SAT_EN
        if (t > Y_MAX) begin
            round_q = {1'b1, 16'h7FFF};
        end else if (t < Y_MIN) begin
            round_q = {1'b1, 16'h8000};
        end else begin
            round_q = {1'b0, 16'(t)};
        end
`else
        round_q = {1'b0, 16'(t)};
`endif
    endfunction

    // rdy_en_q holds in_ready low until the first edge after reset release.
    assign in_ready  = rdy_en_q & ((state_q == S_IDLE) | ((state_q == S_OUT) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_OUT);
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign sat_flag  = sat_q;

    assign prod_ext  = signed'({mul_result[31], mul_result});
    assign rnd_re    = round_q(acc_re_q);
    assign rnd_im    = round_q(acc_im_q);

    // Operand mux kept apart from the accumulate logic: mul_result depends
    // combinationally on these outputs.
    always_comb begin
        mul_multiplier   = '0;
        mul_multiplicand = '0;
        case (state_q)
            S_P0: begin mul_multiplier = ar_q; mul_multiplicand = wr_q; end
            S_P1: begin mul_multiplier = ai_q; mul_multiplicand = wi_q; end
            S_P2: begin mul_multiplier = ar_q; mul_multiplicand = wi_q; end
            S_P3: begin mul_multiplier = ai_q; mul_multiplicand = wr_q; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        ai_d     = ai_q;
        wr_d     = wr_q;
        wi_d     = wi_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        y_re_d   = y_re_q;
        y_im_d   = y_im_q;
        sat_d    = sat_q;

        case (state_q)
            S_IDLE: if (accept) state_d = S_P0;
            S_P0: begin
                acc_re_d = prod_ext;
                state_d  = S_P1;
            end
            S_P1: begin
                acc_re_d = CONJ ? (acc_re_q + prod_ext) : (acc_re_q - prod_ext);
                state_d  = S_P2;
            end
            S_P2: begin
                acc_im_d = CONJ ? -prod_ext : prod_ext;
                state_d  = S_P3;
            end
            S_P3: begin
                acc_im_d = acc_im_q + prod_ext;
                state_d  = S_RND;
            end
            S_RND: begin
                y_re_d  = rnd_re[15:0];
                y_im_d  = rnd_im[15:0];
                sat_d   = rnd_re[16] | rnd_im[16];
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = in_valid ? S_P0 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            ar_d  = a_re;
            ai_d  = a_im;
            wr_d  = w_re;
            wi_d  = w_im;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
            ar_q     <= '0;
            ai_q     <= '0;
            wr_q     <= '0;
            wi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            y_re_q   <= '0;
            y_im_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            wr_q     <= wr_d;
            wi_q     <= wi_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            y_re_q   <= y_re_d;
            y_im_q   <= y_im_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: doc/cmul_seq.md
Name: cmul_seq

Overview:
- Complex twiddle-multiply sequencer for the 64-point FFT datapath; sits between the butterfly/twiddle fetch stage and the shared fixed-point multiplier.
- Accepts one complex sample and one complex twiddle, both Q1.15.
- Time-multiplexes a single external 16x16 combinational signed multiplier over four cycles and accumulates the partial products.
- Rounds back to Q1.15 and presents the complex product on a valid/ready output.

Parameters:
- FRAC_BITS, 15, fractional bits of input/output format; product is Q2.30, result shift = FRAC_BITS.
- CONJ, 0, 1 = multiply by conjugate twiddle (IFFT direction), 0 = plain twiddle.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample/twiddle valid.
- in_ready  out  1  block can accept input this cycle.
- a_re, a_im  in  16 each  sample, signed Q1.15.
- w_re, w_im  in  16 each  twiddle, signed Q1.15.
- mul_multiplier  out  16  operand A to shared multiplier.
- mul_multiplicand  out  16  operand B to shared multiplier.
- mul_result  in  32  signed product from multiplier, combinational, same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y_re, y_im  out  16 each  result, signed Q1.15.
- sat_flag  out  1  current result was saturated (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, accumulators=0, operand regs=0, out_valid=0, y_re=y_im=0, sat_flag=0; in_ready goes to 1 one cycle after release.
- Mid-operation reset aborts the operation; no partial result is emitted.
- Input handshake:
  - in_ready = (state==IDLE) | (state==OUT & out_ready).
  - Transfer occurs when in_valid & in_ready; a_*/w_* are registered at that edge.
- FSM states: IDLE, P0, P1, P2, P3, RND, OUT.
  - IDLE --accept--> P0 -> P1 -> P2 -> P3 -> RND -> OUT, each unconditional after one cycle.
  - OUT: if out_ready & in_valid -> P0 (back-to-back accept).
  - OUT: elif out_ready -> IDLE.
  - OUT: else hold, with y_*, out_valid and sat_flag stable.
- Product schedule (operands driven combinationally from registered inputs by state; mul_result captured at end of state):
  - P0: ar*wr -> acc_re = +p.
  - P1: ai*wi -> acc_re -= p (CONJ=0) or += p (CONJ=1).
  - P2: ar*wi -> acc_im = +p (CONJ=0) or -p (CONJ=1).
  - P3: ai*wr -> acc_im += p.
  - IDLE/RND/OUT: mul operands driven 0.
- Accumulators are 33-bit signed, since the worst case |sum| is 2^31.
- The 32-bit product is sign-extended to 33 bits before accumulation.
- RND, applied per component:
  - t = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round-half-up).
  - t is then saturated or wrapped to 16 bits (see Optional Feature).
  - Results are registered into y_* at the end of RND; out_valid=1 in OUT.
- Latency: accept edge to out_valid high = 5 clocks (6 edges counting the accept edge).
- Throughput: one result per 6 clocks with out_ready held high.
- Input values are never modified while busy; in_valid during P0..RND is ignored (in_ready=0).
- The multiplier operand 0x8000 is legal: (-1)*(-1) yields +2^30 and must accumulate correctly.

Optional Feature:
- Macro CMUL_SAT_EN.
- Defined: t outside [-32768, 32767] clamps to 0x8000/0x7FFF. sat_flag=1 in OUT if either component clamped; it is cleared on the next accept.
- Undefined: t is truncated to its low 16 bits (two's-complement wrap). sat_flag is tied to 0.

Test Plan:
- Scale: a=(0x4000,0x0000), w=(0x4000,0x0000) -> y=(0x2000,0x0000), out_valid high 5 clocks after accept.
- Twiddle -j, CONJ=0: a=(0x4000,0x2000), w=(0x0000,0x8000) -> y=(0x2000,0xC000).
- Same inputs with CONJ=1 -> y=(0xE000,0x4000).
- Overflow: a=(0x8000,0x8000), w=(0x8000,0x7FFF):
  - With CMUL_SAT_EN -> y=(0x7FFF,0x0001), sat_flag=1.
  - Without -> y=(0xFFFF,0x0001), sat_flag=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y/out_valid stable and in_ready=0. Then raise out_ready with in_valid=1 -> same-edge accept, next result 5 clocks later.
- Reset mid-op: assert reset_n=0 in P2 -> out_valid=0 immediately, no result emitted. After release, a fresh 0.5*0.5 input gives 0x2000 with no residue from the aborted operation.
